// File: rtl/ov5640_cfg_seq.sv
// ---------------------------------------------------------------------------
// ov5640_cfg_seq
//
// Register-table sequencer for the OV5640 SCCB configuration engine. Once the
// camera power sequence has finished, a rising edge on cfg_go walks a table
// of 32-bit entries. Each ordinary entry becomes one estart pulse plus a write
// word handed to the IIC write engine. Entries with device byte 0x00 end the
// table, and entries with device byte 0xFF insert a millisecond-style delay.
// A NACKed or timed-out write is re-issued up to RETRY_MAX times before the
// run aborts.
//
// Ports:
//   sclk        system clock, all logic on the rising edge
//   s_rst       synchronous active-high reset
//   power_done  level, camera power/reset sequence finished
//   cfg_go      level, rising edge requests a (re)configuration run
//   tbl_addr    table read address (ROM data valid one cycle later)
//   tbl_data    entry: [31:24] device, [23:8] register, [7:0] value
//   estart      one-cycle start pulse to the IIC engine
//   ewdata      write word, stable from estart until done/err
//   iic_done    one-cycle pulse, write acknowledged
//   iic_err     one-cycle pulse, NACK
//   cfg_busy    high while a run is in progress
//   cfg_done    sticky, table completed successfully
//   cfg_err     sticky, run aborted
//   err_idx     index of the aborting entry
// ---------------------------------------------------------------------------
module ov5640_cfg_seq #(
  parameter int TBL_AW    = 8,
  parameter int DLY_UNIT  = 50000,
  parameter int RETRY_MAX = 3,
  parameter int TO_CYC    = 200000
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              power_done,
  input  logic              cfg_go,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic              estart,
  output logic [31:0]       ewdata,
  input  logic              iic_done,
  input  logic              iic_err,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int TO_W  = (TO_CYC > 1)   ? $clog2(TO_CYC)   : 1;
  localparam int PRE_W = (DLY_UNIT > 1) ? $clog2(DLY_UNIT) : 1;
  localparam int RTY_W = ($clog2(RETRY_MAX + 1) > 2) ? $clog2(RETRY_MAX + 1) : 2;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DLY_UNIT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(RETRY_MAX);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_PWR  = 4'd1;
  localparam logic [3:0] S_FETCH     = 4'd2;
  localparam logic [3:0] S_DECODE    = 4'd3;
  localparam logic [3:0] S_ISSUE     = 4'd4;
  localparam logic [3:0] S_WAIT_DONE = 4'd5;
  localparam logic [3:0] S_DELAY     = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  logic [3:0]        state_q,    state_d;
  logic [1:0]        go_sr_q,    go_sr_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [31:0]       ewdata_q,   ewdata_d;
  logic              estart_q,   estart_d;
  logic              cfg_busy_q, cfg_busy_d;
  logic              cfg_done_q, cfg_done_d;
  logic              cfg_err_q,  cfg_err_d;
  logic [TBL_AW-1:0] err_idx_q,  err_idx_d;
  logic [RTY_W-1:0]  retry_q,    retry_d;
  logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
  logic [PRE_W-1:0]  pre_q,      pre_d;
  logic [15:0]       dly_q,      dly_d;

  logic start;
  logic fail;

  // Rising edge of the synchronised cfg_go request.
  assign start = go_sr_q[0] & ~go_sr_q[1];

  // A write fails on NACK or when the response window runs out; a done pulse
  // coinciding with a NACK still counts as a failure.
  assign fail = iic_err | (to_cnt_q == TO_LAST);

  always_comb begin
    // NOTE: every *_d starts from its held value so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    go_sr_d    = {go_sr_q[0], cfg_go};
    tbl_addr_d = tbl_addr_q;
    ewdata_d   = ewdata_q;
    cfg_busy_d = cfg_busy_q;
    cfg_done_d = cfg_done_q;
    cfg_err_d  = cfg_err_q;
    err_idx_d  = err_idx_q;
    retry_d    = retry_q;
    to_cnt_d   = to_cnt_q;
    pre_d      = pre_q;
    dly_d      = dly_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_done_d = 1'b0;
          cfg_err_d  = 1'b0;
          retry_d    = '0;
          tbl_addr_d = '0;
          cfg_busy_d = 1'b1;
          state_d    = S_WAIT_PWR;
        end
      end

      S_WAIT_PWR: begin
        if (power_done) state_d = S_FETCH;
      end

      // tbl_addr is already stable; this cycle covers the ROM read latency.
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        case (tbl_data[31:24])
          8'h00: state_d = S_DONE;
          8'hFF: begin
            dly_d   = tbl_data[15:0];
            pre_d   = '0;
            state_d = (tbl_data[15:0] == 16'd0) ? S_NEXT : S_DELAY;
          end
          default: begin
            ewdata_d = tbl_data;
            state_d  = S_ISSUE;
          end
        endcase
      end

      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fail) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERR;
          end
        end else if (iic_done) begin
          state_d = S_NEXT;
        end
      end

      // pre_q counts cycles within one tick; dly_q counts remaining ticks.
      S_DELAY: begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          dly_d = dly_q - 16'd1;
          if (dly_q == 16'd1) state_d = S_NEXT;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      S_NEXT: begin
        retry_d = '0;
        // Running off the end of the address space ends the table.
        if (&tbl_addr_q) begin
          state_d = S_DONE;
        end else begin
          tbl_addr_d = tbl_addr_q + TBL_AW'(1);
          state_d    = S_FETCH;
        end
      end

      S_DONE: begin
        cfg_done_d = 1'b1;
        cfg_busy_d = 1'b0;
        state_d    = S_IDLE;
      end

      S_ERR: begin
        cfg_err_d  = 1'b1;
        err_idx_d  = tbl_addr_q;
        cfg_busy_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // estart is registered, so it is high for exactly the single ISSUE cycle.
    estart_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge sclk) begin
    // NOTE: the block has no storage array, so every flop takes the reset;
    // that also guarantees no estart can fire in the cycle after a reset.
    if (s_rst) begin
      state_q    <= S_IDLE;
      go_sr_q    <= '0;
      tbl_addr_q <= '0;
      ewdata_q   <= '0;
      estart_q   <= 1'b0;
      cfg_busy_q <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      err_idx_q  <= '0;
      retry_q    <= '0;
      to_cnt_q   <= '0;
      pre_q      <= '0;
      dly_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop updates from the
      // values computed before the edge, independent of statement order.
      state_q    <= state_d;
      go_sr_q    <= go_sr_d;
      tbl_addr_q <= tbl_addr_d;
      ewdata_q   <= ewdata_d;
      estart_q   <= estart_d;
      cfg_busy_q <= cfg_busy_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      err_idx_q  <= err_idx_d;
      retry_q    <= retry_d;
      to_cnt_q   <= to_cnt_d;
      pre_q      <= pre_d;
      dly_q      <= dly_d;
    end
  end

  assign tbl_addr = tbl_addr_q;
  assign estart   = estart_q;
  assign ewdata   = ewdata_q;
  assign cfg_busy = cfg_busy_q;
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_ov5640_cfg_seq
//
// Self-checking bench for ov5640_cfg_seq. A bench-side ROM answers table
// reads one cycle late, and an engine responder answers every estart with a
// planned done / NACK / both / silence after a planned delay. A table of
// directed vectors covers the documented scenarios, hand-written sequences
// cover power gating, timeout, wrap-around and reset, and randomized tables
// are compared against a transaction-level model of the run.
// ---------------------------------------------------------------------------
module tb_ov5640_cfg_seq;

  localparam int AW        = 4;
  localparam int DEPTH     = 1 << AW;
  localparam int DLY_UNIT  = 10;
  localparam int RETRY_MAX = 3;
  localparam int TO_CYC    = 64;
  localparam int NPLAN     = 64;

  localparam int R_DONE = 0;
  localparam int R_ERR  = 1;
  localparam int R_BOTH = 2;
  localparam int R_NONE = 3;

  logic          sclk;
  logic          s_rst;
  logic          power_done;
  logic          cfg_go;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_data;
  logic          estart;
  logic [31:0]   ewdata;
  logic          iic_done;
  logic          iic_err;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;
  logic [AW-1:0] err_idx;

  ov5640_cfg_seq #(
    .TBL_AW   (AW),
    .DLY_UNIT (DLY_UNIT),
    .RETRY_MAX(RETRY_MAX),
    .TO_CYC   (TO_CYC)
  ) dut (
    .sclk      (sclk),
    .s_rst     (s_rst),
    .power_done(power_done),
    .cfg_go    (cfg_go),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .estart    (estart),
    .ewdata    (ewdata),
    .iic_done  (iic_done),
    .iic_err   (iic_err),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_idx   (err_idx)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  logic [31:0] rom [DEPTH];
  always @(posedge sclk) tbl_data <= rom[tbl_addr];

  // Engine response plan, indexed by estart number within a run.
  int plan_k [NPLAN];
  int plan_d [NPLAN];
  int plan_ptr;
  int resp_cnt  = 0;
  int resp_kind = R_DONE;

  logic [31:0] log_w [$];
  int          log_c [$];

  logic [31:0] model_w [$];
  logic        model_err;
  int          model_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [15:0] plan;      // 2 bits per estart: response kind
    int          n_est;
    logic [31:0] w_first;
    logic [31:0] w_last;
    int          lat;       // cycles from cfg_go drive to first estart, -1 = none
    int          gap;       // cycles between first two estarts, -1 = skip
    logic        exp_done;
    logic        exp_err;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int kind_at(input int k);
    return (k < NPLAN) ? plan_k[k] : R_DONE;
  endfunction

  function automatic int dly_at(input int k);
    return (k < NPLAN) ? plan_d[k] : 20;
  endfunction

  task automatic set_plan_default();
    for (int j = 0; j < NPLAN; j++) begin
      plan_k[j] = R_DONE;
      plan_d[j] = 20;
    end
  endtask

  // Monitor and IIC engine model, both working on the falling edge.
  initial begin
    iic_done = 1'b0;
    iic_err  = 1'b0;
    forever begin
      @(negedge sclk);
      if (estart) begin
        log_w.push_back(ewdata);
        log_c.push_back(cyc);
      end
      iic_done = 1'b0;
      iic_err  = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          iic_done = (resp_kind == R_DONE) || (resp_kind == R_BOTH);
          iic_err  = (resp_kind == R_ERR)  || (resp_kind == R_BOTH);
        end
      end
      if (estart) begin
        resp_kind = kind_at(plan_ptr);
        if (resp_kind != R_NONE) resp_cnt = dly_at(plan_ptr);
        plan_ptr++;
      end
    end
  end

  // Transaction-level model: list of writes and final outcome of one run.
  task automatic model_run();
    int          idx;
    int          k;
    int          tries;
    bit          fin;
    bit          ok;
    logic [31:0] e;
    logic [7:0]  dev;
    model_w.delete();
    model_err = 1'b0;
    model_idx = 0;
    idx = 0;
    k   = 0;
    fin = 0;
    while (!fin) begin
      e   = rom[idx];
      dev = e[31:24];
      if (dev == 8'h00) begin
        fin = 1;
      end else begin
        if (dev != 8'hFF) begin
          tries = 0;
          ok    = 0;
          while (!ok && !fin) begin
            model_w.push_back(e);
            if (kind_at(k) == R_DONE) ok = 1;
            else if (tries == RETRY_MAX) begin
              fin       = 1;
              model_err = 1'b1;
              model_idx = idx;
            end else tries++;
            k++;
          end
        end
        if (!fin) begin
          if (idx == DEPTH - 1) fin = 1;
          else idx++;
        end
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int n = 0; n < budget && cfg_busy; n++) @(negedge sclk);
    check({name, "_finished"}, 32'(cfg_busy), 32'd0);
  endtask

  // Pulse cfg_go and wait for the run to complete; c0 is the drive cycle.
  task automatic do_run(input string name, output int c0);
    cfg_go = 1'b0;
    repeat (2) @(negedge sclk);
    log_w.delete();
    log_c.delete();
    plan_ptr = 0;
    cfg_go = 1'b1;
    c0 = cyc;
    repeat (2) @(negedge sclk);
    cfg_go = 1'b0;
    check({name, "_busy_lat"}, 32'(cfg_busy), 32'd1);
    wait_idle(name, 20000);
  endtask

  task automatic compare_run(input string name);
    check({name, "_n_writes"}, log_w.size(), model_w.size());
    for (int i = 0; i < model_w.size() && i < log_w.size(); i++)
      check({name, "_ewdata"}, log_w[i], model_w[i]);
    check({name, "_done"}, 32'(cfg_done), 32'(!model_err));
    check({name, "_err"}, 32'(cfg_err), 32'(model_err));
    if (model_err) check({name, "_err_idx"}, 32'(err_idx), model_idx);
  endtask

  task automatic random_table();
    int r;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      rom[i] = 32'h0;
      else if (r <= 2) rom[i] = {8'hFF, 8'h00, 16'($urandom_range(0, 2))};
      else             rom[i] = {8'($urandom_range(1, 254)), 24'($urandom)};
    end
    for (int j = 0; j < NPLAN; j++) begin
      r = $urandom_range(0, 19);
      if (r < 14)      plan_k[j] = R_DONE;
      else if (r < 18) plan_k[j] = R_ERR;
      else if (r < 19) plan_k[j] = R_BOTH;
      else             plan_k[j] = R_NONE;
      plan_d[j] = $urandom_range(1, 6);
    end
  endtask

  initial begin
    int    c0;
    string nm;

    vecs[0] = '{32'h78300800, 32'h78310301, 32'h0, 16'h0000, 2, 32'h78300800, 32'h78310301,  5, 24, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{32'hFF000005, 32'h78300801, 32'h0, 16'h0000, 1, 32'h78300801, 32'h78300801, 58, -1, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{32'h78300800, 32'h78310301, 32'h0, 16'h0005, 4, 32'h78300800, 32'h78310301,  5, 21, 1'b1, 1'b0, 4'd0};
    vecs[3] = '{32'h78300800, 32'h78310301, 32'h0, 16'h0154, 5, 32'h78300800, 32'h78310301,  5, 24, 1'b0, 1'b1, 4'd1};
    vecs[4] = '{32'h78300800, 32'h78310301, 32'h0, 16'h0002, 3, 32'h78300800, 32'h78310301,  5, 21, 1'b1, 1'b0, 4'd0};
    vecs[5] = '{32'hFF000000, 32'h78300801, 32'h0, 16'h0000, 1, 32'h78300801, 32'h78300801,  8, -1, 1'b1, 1'b0, 4'd0};
    vecs[6] = '{32'h00000000, 32'h78300801, 32'h0, 16'h0000, 0, 32'h0,        32'h0,        -1, -1, 1'b1, 1'b0, 4'd0};
    vecs[7] = '{32'h78300800, 32'h78310301, 32'h0, 16'h0015, 5, 32'h78300800, 32'h78310301,  5, 21, 1'b1, 1'b0, 4'd0};

    s_rst      = 1'b1;
    power_done = 1'b1;
    cfg_go     = 1'b0;
    plan_ptr   = 0;
    set_plan_default();
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
    repeat (3) @(negedge sclk);

    check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    check("rst_estart",   32'(estart),   32'd0);
    check("rst_ewdata",   ewdata,        32'd0);
    check("rst_busy",     32'(cfg_busy), 32'd0);
    check("rst_done",     32'(cfg_done), 32'd0);
    check("rst_err",      32'(cfg_err),  32'd0);
    check("rst_err_idx",  32'(err_idx),  32'd0);
    s_rst = 1'b0;

    // Directed vectors.
    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d", v);
      set_plan_default();
      for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
      rom[0] = vecs[v].t0;
      rom[1] = vecs[v].t1;
      rom[2] = vecs[v].t2;
      for (int j = 0; j < 8; j++) plan_k[j] = int'(vecs[v].plan[2*j +: 2]);
      do_run(nm, c0);
      model_run();
      compare_run(nm);
      check({nm, "_n_est"}, log_w.size(), vecs[v].n_est);
      check({nm, "_cfg_done"}, 32'(cfg_done), 32'(vecs[v].exp_done));
      check({nm, "_cfg_err"}, 32'(cfg_err), 32'(vecs[v].exp_err));
      if (vecs[v].exp_err) check({nm, "_err_idx_v"}, 32'(err_idx), 32'(vecs[v].exp_idx));
      if (vecs[v].n_est > 0 && log_w.size() > 0) begin
        check({nm, "_w_first"}, log_w[0], vecs[v].w_first);
        check({nm, "_w_last"}, log_w[log_w.size()-1], vecs[v].w_last);
      end
      if (vecs[v].lat >= 0 && log_c.size() > 0)
        check({nm, "_first_estart_lat"}, log_c[0] - c0, vecs[v].lat);
      if (vecs[v].gap >= 0 && log_c.size() > 1)
        check({nm, "_estart_gap"}, log_c[1] - log_c[0], vecs[v].gap);
    end

    // Power gating, then a silent engine: retries on timeout and abort.
    set_plan_default();
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
    rom[0] = 32'h78300800;
    rom[1] = 32'h78310301;
    for (int j = 0; j < 4; j++) plan_k[j] = R_NONE;
    power_done = 1'b0;
    repeat (2) @(negedge sclk);
    log_w.delete();
    log_c.delete();
    plan_ptr = 0;
    cfg_go = 1'b1;
    repeat (100) @(negedge sclk);
    check("pwr_no_estart", log_w.size(), 0);
    check("pwr_busy", 32'(cfg_busy), 32'd1);
    power_done = 1'b1;
    for (int n = 0; n < 20 && log_w.size() == 0; n++) @(negedge sclk);
    power_done = 1'b0;  // a late drop must not stall the run
    wait_idle("timeout", 2000);
    check("to_n_est", log_w.size(), 4);
    for (int i = 0; i < 3 && i + 1 < log_c.size(); i++)
      check("to_reissue_gap", log_c[i+1] - log_c[i], TO_CYC + 1);
    check("to_err", 32'(cfg_err), 32'd1);
    check("to_done", 32'(cfg_done), 32'd0);
    check("to_err_idx", 32'(err_idx), 32'd0);
    cfg_go     = 1'b0;
    power_done = 1'b1;

    // Full table without an end marker: address wrap ends the run.
    set_plan_default();
    for (int i = 0; i < DEPTH; i++) rom[i] = {8'h78, 16'(i), 8'(i * 3)};
    for (int j = 0; j < NPLAN; j++) plan_d[j] = 2;
    do_run("wrap", c0);
    model_run();
    compare_run("wrap");
    check("wrap_n_est", log_w.size(), DEPTH);
    check("wrap_done", 32'(cfg_done), 32'd1);

    // Reset in the middle of WAIT_DONE, then a fresh run from entry 0.
    set_plan_default();
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h0;
    rom[0] = 32'h78300800;
    rom[1] = 32'h78310301;
    repeat (2) @(negedge sclk);
    log_w.delete();
    log_c.delete();
    plan_ptr = 0;
    cfg_go = 1'b1;
    repeat (2) @(negedge sclk);
    cfg_go = 1'b0;
    for (int n = 0; n < 20 && log_w.size() == 0; n++) @(negedge sclk);
    repeat (5) @(negedge sclk);
    check("pre_rst_busy", 32'(cfg_busy), 32'd1);
    s_rst    = 1'b1;
    resp_cnt = 0;
    @(negedge sclk);
    check("mrst_tbl_addr", 32'(tbl_addr), 32'd0);
    check("mrst_estart",   32'(estart),   32'd0);
    check("mrst_ewdata",   ewdata,        32'd0);
    check("mrst_busy",     32'(cfg_busy), 32'd0);
    check("mrst_done",     32'(cfg_done), 32'd0);
    check("mrst_err",      32'(cfg_err),  32'd0);
    check("mrst_err_idx",  32'(err_idx),  32'd0);
    s_rst = 1'b0;
    repeat (10) @(negedge sclk);
    check("mrst_no_extra_estart", log_w.size(), 1);
    check("mrst_idle_busy", 32'(cfg_busy), 32'd0);
    do_run("restart", c0);
    model_run();
    compare_run("restart");
    if (log_c.size() > 0) check("restart_lat", log_c[0] - c0, 5);

    // Randomized tables and engine behaviour against the model.
    for (int it = 0; it < 12; it++) begin
      nm = $sformatf("rand%0d", it);
      random_table();
      do_run(nm, c0);
      model_run();
      compare_run(nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
- Register-table sequencer for the OV5640 SCCB configuration engine.
- After camera power-up completes, it walks a 32-bit entry table and issues one start pulse plus write word per entry to the IIC write engine.
- Between writes it waits for the engine's done or error response; table-encoded delay and end entries are handled internally.
- Sits between the power controller, the config ROM and the IIC engine; reports busy, done and error status to the system.

Parameters:
- TBL_AW, 8: table address width; max 2^TBL_AW entries.
- DLY_UNIT, 50000: sclk cycles per delay tick (1 ms at 50 MHz).
- RETRY_MAX, 3: re-issues of a NACKed entry before abort.
- TO_CYC, 200000: sclk cycles allowed for the engine to return done/err per write.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- s_rst  in  1  synchronous, active-high reset.
- power_done  in  1  level; camera power/reset sequence finished.
- cfg_go  in  1  level; rising edge requests a (re)configuration run.
- tbl_addr  out  TBL_AW  table read address; ROM data valid 1 cycle later.
- tbl_data  in  32  entry: [31:24] device byte, [23:8] register address, [7:0] value.
- estart  out  1  one-cycle start pulse to the IIC engine.
- ewdata  out  32  write word; held stable from the estart cycle until done/err.
- iic_done  in  1  one-cycle pulse; write acknowledged.
- iic_err  in  1  one-cycle pulse; NACK.
- cfg_busy  out  1  high while a run is in progress.
- cfg_done  out  1  sticky; table completed successfully.
- cfg_err  out  1  sticky; run aborted.
- err_idx  out  TBL_AW  index of the aborting entry.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset during any state aborts immediately and returns to IDLE with no estart.
- Edge detect: cfg_go is sampled into a 2-bit shift register; start = q[0] & ~q[1].
- State machine:
  - IDLE: on start, clear cfg_done, cfg_err and retry_cnt; set tbl_addr=0 and cfg_busy=1; go to WAIT_PWR. Other cfg_go edges are ignored while busy.
  - WAIT_PWR: hold until power_done=1, then go to FETCH.
  - FETCH: 1 cycle for the ROM read latency, then go to DECODE.
  - DECODE: branch on tbl_data[31:24]:
    - 0x00: end marker; go to DONE.
    - 0xFF: delay entry; load dly_cnt=tbl_data[15:0] ticks and go to DELAY. A tick count of 0 goes straight to NEXT.
    - Otherwise: latch ewdata=tbl_data and go to ISSUE.
  - ISSUE: estart=1 for exactly 1 cycle; clear to_cnt; go to WAIT_DONE.
  - WAIT_DONE:
    - iic_done: go to NEXT.
    - iic_err, or to_cnt reaching TO_CYC-1: if retry_cnt<RETRY_MAX, increment retry_cnt and return to ISSUE; else go to ERR.
    - iic_done and iic_err in the same cycle: treated as error.
  - DELAY: a prescaler counts DLY_UNIT cycles per tick; after dly_cnt ticks go to NEXT.
  - NEXT: clear retry_cnt. If tbl_addr is the all-ones index, go to DONE (wrap-around counts as implicit end). Otherwise increment tbl_addr and go to FETCH.
  - DONE: cfg_done=1, cfg_busy=0; go to IDLE.
  - ERR: cfg_err=1, err_idx=tbl_addr, cfg_busy=0; go to IDLE.
- Latency: a start edge in cycle N sets cfg_busy in N+1. With power_done already high, the first estart occurs 4 cycles after the start edge is detected. Minimum spacing between consecutive writes is 3 cycles after iic_done.
- Widths: to_cnt is clog2(TO_CYC) bits. The prescaler is clog2(DLY_UNIT) bits. dly_cnt is 16 bits. retry_cnt is 2 bits minimum, sized for RETRY_MAX.
- A power_done drop after WAIT_PWR is ignored; the run continues.

Test Plan:
- Normal run: table {0x78300800, 0x78310301, 0x00000000}, power_done=1, engine returns iic_done 20 cycles after each estart → exactly 2 estart pulses with ewdata 0x78300800 then 0x78310301; cfg_done=1, cfg_busy=0, cfg_err=0.
- Delay entry: DLY_UNIT=10, table {0xFF000005, 0x78300801, 0} → estart occurs at least 50 cycles after leaving DECODE of entry 0; 0xFF entry never produces estart; cfg_done=1.
- NACK retry: entry 0 gets iic_err twice then iic_done → 3 estart pulses carrying the same ewdata; run completes with cfg_done=1.
- Abort: entry 1 always NACKs with RETRY_MAX=3 → 1+4 estart pulses total; cfg_err=1, err_idx=1, cfg_done=0.
- Timeout and power gating:
  - Hold cfg_go high with power_done=0 for 100 cycles → no estart; cfg_busy=1.
  - Raise power_done, then give entry 0 no response; with TO_CYC=64, estart re-issues every 64+1 cycles, then ERR with err_idx=0.
- Reset mid-run: assert s_rst during WAIT_DONE → next cycle all outputs 0. A fresh cfg_go edge restarts from tbl_addr=0.
